dm_access_ctrl: RTL and testbench

- Memory-stage initiator that drives the data memory's WE2/Addr/WriDat/ReaDat port.
- Accepts byte/half/word load and store requests from the pipeline over a valid/ready handshake.
- Sub-word stores are done as read-modify-write, because the data memory has one word-wide write enable.
- Returns load data (sign- or zero-extended) or a store completion on a valid/ready response channel.

---
 rtl/dm_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_dm_access_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl.sv
// Memory-stage initiator for the single-port data memory: byte/half/word loads
// and stores, with sub-word stores done as read-modify-write.
module dm_access_ctrl #(
  parameter int AWIDTH  = 32,
  parameter int ALENGTH = 128,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // Handshakes: a beat transfers on the rising edge where valid & ready are both 1;
  // the sender holds valid and its payload stable until then.
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [AWIDTH-1:0] ReqAddr,
  input  logic [AWIDTH-1:0] ReqData,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [AWIDTH-1:0] RespData,
  output logic              RespErr,
  output logic              WE2,
  output logic [AWIDTH-1:0] Addr,
  output logic [AWIDTH-1:0] WriDat,
  input  logic [AWIDTH-1:0] ReaDat,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t            r_state;
  logic              r_write;
  logic              r_signed;
  logic [1:0]        r_size;
  logic [1:0]        r_lane;
  logic [AWIDTH-1:0] r_data;
  logic [CW-1:0]     r_cnt;

  logic [AWIDTH-1:0] w_idx;
  logic              w_err;
  logic              w_rd_last;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [AWIDTH-1:0] w_load;
  logic [AWIDTH-1:0] w_merged;

  assign o_dbg_state = r_state;
  assign w_idx       = {2'b00, ReqAddr[AWIDTH-1:2]};
  assign w_rd_last   = (r_cnt == CW'(RD_LAT - 1));
  assign w_err       = (ReqSize == 2'b11)
                     || (ReqSize == 2'b01 && ReqAddr[0])
                     || (ReqSize == 2'b10 && ReqAddr[1:0] != 2'b00)
                     || (w_idx >= AWIDTH'(ALENGTH));

  // Lane extraction for loads and lane insertion for sub-word stores (little-endian).
  always_comb begin
    w_byte   = ReaDat[{r_lane, 3'b000} +: 8];
    w_half   = ReaDat[{r_lane[1], 4'b0000} +: 16];
    w_load   = ReaDat;
    w_merged = ReaDat;
    case (r_size)
      2'b00: begin
        w_load = {{(AWIDTH-8){r_signed & w_byte[7]}}, w_byte};
        w_merged[{r_lane, 3'b000} +: 8] = r_data[7:0];
      end
      2'b01: begin
        w_load = {{(AWIDTH-16){r_signed & w_half[15]}}, w_half};
        w_merged[{r_lane[1], 4'b0000} +: 16] = r_data[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_write   <= 1'b0;
      r_signed  <= 1'b0;
      r_size    <= 2'b00;
      r_lane    <= 2'b00;
      r_data    <= '0;
      r_cnt     <= '0;
      ReqReady  <= 1'b1;
      RespValid <= 1'b0;
      RespData  <= '0;
      RespErr   <= 1'b0;
      WE2       <= 1'b0;
      Addr      <= '0;
      WriDat    <= '0;
    end else begin
      case (r_state)
        IDLE: if (ReqValid && ReqReady) begin
          ReqReady <= 1'b0;
          r_write  <= ReqWrite;
          r_signed <= ReqSigned;
          r_size   <= ReqSize;
          r_lane   <= ReqAddr[1:0];
          r_data   <= ReqData;
          r_cnt    <= '0;
          Addr     <= w_idx;
          if (w_err) begin
            r_state   <= RESP;
            RespValid <= 1'b1;
            RespErr   <= 1'b1;
            RespData  <= '0;
          end else if (ReqWrite && ReqSize == 2'b10) begin
            r_state <= WR;
            WE2     <= 1'b1;
            WriDat  <= ReqData;
          end else begin
            r_state <= RD;
          end
        end
        RD: begin
          if (w_rd_last) begin
            if (r_write) begin
              r_state <= WR;
              WE2     <= 1'b1;
              WriDat  <= w_merged;
            end else begin
              r_state   <= RESP;
              RespValid <= 1'b1;
              RespData  <= w_load;
              RespErr   <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WR: begin
          WE2       <= 1'b0;
          r_state   <= RESP;
          RespValid <= 1'b1;
          RespData  <= '0;
          RespErr   <= 1'b0;
        end
        RESP: if (RespReady) begin
          r_state   <= IDLE;
          RespValid <= 1'b0;
          RespData  <= '0;
          RespErr   <= 1'b0;
          ReqReady  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: bench-owned data memory, word-level reference model,
// directed cases followed by random transactions.
module tb_dm_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ReqValid, ReqReady, ReqWrite, ReqSigned;
  logic [1:0]  ReqSize;
  logic [31:0] ReqAddr, ReqData;
  logic        RespValid, RespReady, RespErr;
  logic [31:0] RespData;
  logic        WE2;
  logic [31:0] Addr, WriDat, ReaDat;
  logic [1:0]  dbg_state;

  dm_access_ctrl #(.AWIDTH(32), .ALENGTH(128), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData), .RespErr(RespErr),
    .WE2(WE2), .Addr(Addr), .WriDat(WriDat), .ReaDat(ReaDat),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench memory ----------------
  logic [31:0] mem [0:127];
  logic [31:0] model_mem [0:127];
  logic        bk_we;
  logic [6:0]  bk_idx;
  logic [31:0] bk_dat;

  always @(posedge clk) begin
    if (bk_we) mem[bk_idx] <= bk_dat;
    else if (WE2 && Addr < 32'd128) mem[Addr[6:0]] <= WriDat;
  end
  assign ReaDat = (Addr < 32'd128) ? mem[Addr[6:0]] : 32'h0;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] err_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic void model(input logic wr, input logic [1:0] sz, input logic sgn,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic err, output logic [31:0] rdata,
                                output logic [31:0] wdat, output int lat, output int pulses);
    int unsigned idx, sh;
    logic [31:0] mask, word, val;
    idx    = a >> 2;
    err    = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (idx >= 128);
    rdata  = 32'h0;
    wdat   = 32'h0;
    pulses = 0;
    if (err) begin
      lat = 1;
      return;
    end
    mask = (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    sh   = 8 * (a % 4);
    word = model_mem[idx];
    if (!wr) begin
      val = (word >> sh) & mask;
      if (sgn && (val & ((mask >> 1) + 1)) != 0) val = val | ~mask;
      rdata = val;
      lat   = 2;
    end else begin
      wdat   = (word & ~(mask << sh)) | ((d & mask) << sh);
      lat    = (sz == 2'd2) ? 2 : 3;
      pulses = 1;
      model_mem[idx] = wdat;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic poke(input int idx, input logic [31:0] val);
    bk_we = 1'b1; bk_idx = idx[6:0]; bk_dat = val;
    @(posedge clk);
    @(negedge clk);
    bk_we = 1'b0;
    model_mem[idx] = val;
  endtask

  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] d, input int hold);
    logic        e_err;
    logic [31:0] e_data, e_wdat, hold_data;
    int          e_lat, e_pulses, cyc, pulses, w;
    model(wr, sz, sgn, a, d, e_err, e_data, e_wdat, e_lat, e_pulses);
    exp_q.push_back(e_data);
    err_q.push_back({31'd0, e_err});
    ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqSigned = sgn;
    ReqAddr = a; ReqData = d; RespReady = (hold == 0);
    w = 0;
    while (!ReqReady && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq("req_ready_idle", ReqReady, 1'b1);
    @(posedge clk);
    @(negedge clk);
    ReqValid = 1'b0;
    cyc = 1;
    pulses = 0;
    while (1) begin
      if (WE2) begin
        pulses++;
        check_eq("we_addr", Addr, a >> 2);
        check_eq("we_wridat", WriDat, e_wdat);
      end
      if (RespValid || cyc >= 20) break;
      check_eq("req_ready_busy", ReqReady, 1'b0);
      @(negedge clk);
      cyc++;
    end
    check_eq("resp_valid", RespValid, 1'b1);
    check_eq("resp_latency", cyc, e_lat);
    check_eq("we_pulses", pulses, e_pulses);
    check_eq("resp_data", RespData, exp_q.pop_front());
    check_eq("resp_err", RespErr, err_q.pop_front());
    hold_data = RespData;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", RespValid, 1'b1);
      check_eq("hold_data", RespData, hold_data);
      check_eq("hold_req_ready", ReqReady, 1'b0);
    end
    RespReady = 1'b1;
    @(negedge clk);
    check_eq("resp_done", RespValid, 1'b0);
    check_eq("req_ready_after", ReqReady, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we2"}, WE2, 1'b0);
    check_eq({tag, "_addr"}, Addr, 32'h0);
    check_eq({tag, "_wridat"}, WriDat, 32'h0);
    check_eq({tag, "_resp_valid"}, RespValid, 1'b0);
    check_eq({tag, "_resp_data"}, RespData, 32'h0);
    check_eq({tag, "_resp_err"}, RespErr, 1'b0);
    check_eq({tag, "_req_ready"}, ReqReady, 1'b1);
    check_eq({tag, "_dbg_idle"}, dbg_state, 2'd0);
  endtask

  task automatic reset_during_wr();
    int w;
    poke(4, 32'h1122_3344);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd0; ReqSigned = 1'b0;
    ReqAddr = 32'h11; ReqData = 32'h0000_00AA; RespReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ReqValid = 1'b0;
    w = 0;
    while (!WE2 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check_eq("rst_saw_wr", WE2, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rst_no_resp", RespValid, 1'b0);
      check_eq("rst_ready", ReqReady, 1'b1);
    end
    check_eq("rst_mem_kept", mem[4], model_mem[4]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'd0; ReqSigned = 1'b0;
    ReqAddr = '0; ReqData = '0; RespReady = 1'b1;
    bk_we = 1'b0; bk_idx = '0; bk_dat = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 128; i++) poke(i, $urandom);

    run_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    check_eq("mem_word_store", mem[4], 32'hDEAD_BEEF);

    poke(4, 32'h80FF_7F01);
    run_txn(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
    run_txn(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0);
    run_txn(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 0);

    poke(4, 32'h1122_3344);
    run_txn(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AA, 0);
    check_eq("mem_byte_store", mem[4], 32'h1122_AA44);

    run_txn(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 0);
    run_txn(1'b1, 2'd2, 1'b0, 32'h12, 32'h1234_5678, 0);
    run_txn(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 0);

    run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);
    run_txn(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0);

    reset_during_wr();

    for (int t = 0; t < 60; t++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 32'h21F)), $urandom, $urandom_range(0, 3));
    end

    for (int i = 0; i < 128; i++) check_eq("mem_final", mem[i], model_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
